// File: rtl/fpu_op_sequencer_if.sv
// Issue, operand/result and FP register-file write bundle between the decoder/FP units and the sequencer.
// The slave modport is the sequencer side; master is the decoder/unit/register-file side.
interface fpu_op_sequencer_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_op;
  logic        issue_dbl;
  logic [4:0]  issue_fd;
  logic        opnd_latch;
  logic [2:0]  unit_sel;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_cmp;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  modport slave (
    input  issue_valid, issue_op, issue_dbl, issue_fd, res_hi, res_lo, res_cmp,
    output issue_ready, opnd_latch, unit_sel, wb_en, wb_addr, wb_data
  );

  modport master (
    output issue_valid, issue_op, issue_dbl, issue_fd, res_hi, res_lo, res_cmp,
    input  issue_ready, opnd_latch, unit_sel, wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/fpu_op_sequencer.sv
// Multi-cycle FP op sequencer: issue -> EXEC (lat cycles) -> 0..2 writeback beats; optional FPU_STATUS_EN sticky status.
// Latency: lat EXEC cycles then WB_HI (+WB_LO for doubles); c.eq/reserved finish at EXEC exit.
// Backpressure: issue_ready only in IDLE; stall holds the core for the whole operation.
module fpu_op_sequencer #(
  parameter int LAT_ADD   = 2,
  parameter int LAT_MUL   = 3,
  parameter int LAT_DIV   = 8,
  parameter int DBL_EXTRA = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fpu_op_sequencer_if.slave     bus,
  output logic                  fp_cond,
  output logic                  stall,
  output logic                  done
`ifdef FPU_STATUS_EN
  ,
  input  logic [7:0]            unit_status,
  input  logic                  status_clr,
  output logic [7:0]            sticky_status
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] WB_HI = 2'd2;
  localparam logic [1:0] WB_LO = 2'd3;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic        dbl_q;
  logic [4:0]  fd_q;
  logic [31:0] hold_lo;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_data_q;
  logic        fp_cond_q;
  logic        exec_last;

  function automatic logic [4:0] lat_m1(input logic [2:0] op, input logic dbl);
    int lat;
    case (op)
      3'd2:    lat = LAT_MUL;
      3'd3:    lat = LAT_DIV;
      default: lat = LAT_ADD;
    endcase
    if (dbl) lat = lat + DBL_EXTRA;
    return 5'(lat - 1);
  endfunction

  assign exec_last = (state == EXEC) && (cnt == 5'd0);

  // wb_data_q doubles as the high-half hold register: it is loaded with res_hi on EXEC exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      op_q      <= 3'd0;
      dbl_q     <= 1'b0;
      fd_q      <= 5'd0;
      hold_lo   <= 32'd0;
      wb_addr_q <= 5'd0;
      wb_data_q <= 32'd0;
      fp_cond_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.issue_valid) begin
            op_q  <= bus.issue_op;
            dbl_q <= bus.issue_dbl;
            fd_q  <= bus.issue_fd;
            cnt   <= lat_m1(bus.issue_op, bus.issue_dbl);
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == 5'd0) begin
            if (op_q == 3'd4) begin
              fp_cond_q <= bus.res_cmp;
              state     <= IDLE;
            end else if (op_q > 3'd4) begin
              state <= IDLE;
            end else begin
              hold_lo   <= bus.res_lo;
              wb_data_q <= bus.res_hi;
              wb_addr_q <= fd_q;
              state     <= WB_HI;
            end
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        WB_HI: begin
          if (dbl_q) begin
            wb_addr_q <= 5'(fd_q + 5'd1);
            wb_data_q <= hold_lo;
            state     <= WB_LO;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FPU_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_status <= 8'd0;
    end else if (exec_last && (op_q <= 3'd4)) begin
      sticky_status <= (status_clr ? 8'd0 : sticky_status) | unit_status;
    end else if (status_clr) begin
      sticky_status <= 8'd0;
    end
  end
`endif

  assign bus.issue_ready = (state == IDLE);
  assign stall           = (state != IDLE);
  assign bus.opnd_latch  = (state == IDLE) && bus.issue_valid;
  assign bus.unit_sel    = op_q;
  assign bus.wb_en       = (state == WB_HI) || (state == WB_LO);
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign fp_cond         = fp_cond_q;
  assign done            = (exec_last && (op_q >= 3'd4)) ||
                           ((state == WB_HI) && !dbl_q) ||
                           (state == WB_LO);

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Scoreboard bench for fpu_op_sequencer: directed scenarios then random issue traffic against a transaction-level model.
module tb_fpu_op_sequencer;
  localparam int LAT_ADD   = 2;
  localparam int LAT_MUL   = 3;
  localparam int LAT_DIV   = 8;
  localparam int DBL_EXTRA = 1;

  logic clk;
  logic rst_n;
  logic fp_cond, stall, done;
  fpu_op_sequencer_if bus();

`ifdef FPU_STATUS_EN
  logic [7:0] unit_status;
  logic       status_clr;
  logic [7:0] sticky_status;
`endif

  fpu_op_sequencer #(
    .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV), .DBL_EXTRA(DBL_EXTRA)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .fp_cond(fp_cond),
    .stall(stall),
    .done(done)
`ifdef FPU_STATUS_EN
    ,
    .unit_status(unit_status),
    .status_clr(status_clr),
    .sticky_status(sticky_status)
`endif
  );

  typedef struct { int cyc; logic [4:0] addr; logic [31:0] data; } wb_t;
  typedef struct { int cyc; bit is_ceq; bit cond; } done_t;
  typedef struct { int s; int e; logic [2:0] op; } busy_t;

  wb_t   wb_q[$];
  done_t done_q[$];
  int    latch_q[$];
  busy_t busy_q[$];

  int cyc = 0;
  int free_cyc = 0;
  int checks = 0;
  int errors = 0;
  bit last_acc = 0;
  bit force_en = 0;
  logic [31:0] force_hi = 0, force_lo = 0, salt = 0;
  bit force_cmp = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] hi_at(int c);
    return force_en ? force_hi : (salt ^ (32'(c) * 32'h9E3779B1));
  endfunction
  function automatic logic [31:0] lo_at(int c);
    return force_en ? force_lo : (~salt ^ (32'(c) * 32'h85EBCA6B));
  endfunction
  function automatic bit cmp_at(int c);
    return force_en ? force_cmp : ^(salt ^ (32'(c) * 32'h27D4EB2F));
  endfunction
  function automatic int lat_of(logic [2:0] op, bit dbl);
    int base = (op == 3'd2) ? LAT_MUL : (op == 3'd3) ? LAT_DIV : LAT_ADD;
    return base + (dbl ? DBL_EXTRA : 0);
  endfunction

  // One clock of stimulus; when the model sees an idle sequencer, it predicts the whole transaction.
  task automatic drive_cycle(input bit rstv, input bit v, input logic [2:0] op, input bit dbl, input logic [4:0] fd);
    int e;
    @(posedge clk); #1;
    rst_n = rstv;
    if (!rstv) begin
      wb_q.delete(); done_q.delete(); latch_q.delete(); busy_q.delete();
      free_cyc = cyc + 1;
    end
    bus.issue_valid = v;
    bus.issue_op    = op;
    bus.issue_dbl   = dbl;
    bus.issue_fd    = fd;
    bus.res_hi      = hi_at(cyc);
    bus.res_lo      = lo_at(cyc);
    bus.res_cmp     = cmp_at(cyc);
    last_acc = 0;
    if (rstv && v && cyc >= free_cyc) begin
      last_acc = 1;
      e = cyc + lat_of(op, dbl);
      latch_q.push_back(cyc);
      if (op >= 3'd4) begin
        done_q.push_back('{e, op == 3'd4, cmp_at(e)});
        busy_q.push_back('{cyc + 1, e, op});
        free_cyc = e + 1;
      end else begin
        wb_q.push_back('{e + 1, fd, hi_at(e)});
        if (dbl) begin
          wb_q.push_back('{e + 2, 5'(fd + 5'd1), lo_at(e)});
          done_q.push_back('{e + 2, 1'b0, 1'b0});
          busy_q.push_back('{cyc + 1, e + 2, op});
          free_cyc = e + 3;
        end else begin
          done_q.push_back('{e + 1, 1'b0, 1'b0});
          busy_q.push_back('{cyc + 1, e + 1, op});
          free_cyc = e + 2;
        end
      end
    end
  endtask

  task automatic do_issue(input logic [2:0] op, input bit dbl, input logic [4:0] fd);
    int tries = 0;
    last_acc = 0;
    while (!last_acc && tries < 64) begin
      drive_cycle(1, 1, op, dbl, fd);
      tries++;
    end
    chk(last_acc, "issue_accept", 32'(last_acc), 32'd1);
  endtask

  task automatic do_op(input logic [2:0] op, input bit dbl, input logic [4:0] fd);
    do_issue(op, dbl, fd);
    while (cyc + 1 < free_cyc) drive_cycle(1, 0, op, dbl, fd);
  endtask

  // Monitor: compares every output each cycle against the queued predictions.
  logic [4:0]  last_addr = 0;
  logic [31:0] last_data = 0;
  bit exp_cond = 0;
  always @(negedge clk) begin
    bit exp_busy, exp_wb, exp_done, exp_latch, nxt_cond;
    if (!rst_n) begin
      exp_cond = 0; last_addr = 0; last_data = 0;
      chk(bus.issue_ready === 1'b1, "rst_issue_ready", 32'(bus.issue_ready), 32'd1);
      chk(stall === 1'b0, "rst_stall", 32'(stall), 32'd0);
      chk(bus.wb_en === 1'b0, "rst_wb_en", 32'(bus.wb_en), 32'd0);
      chk(done === 1'b0, "rst_done", 32'(done), 32'd0);
      chk(bus.opnd_latch === 1'b0, "rst_opnd_latch", 32'(bus.opnd_latch), 32'd0);
      chk(fp_cond === 1'b0, "rst_fp_cond", 32'(fp_cond), 32'd0);
      chk(bus.wb_addr === 5'd0, "rst_wb_addr", 32'(bus.wb_addr), 32'd0);
      chk(bus.wb_data === 32'd0, "rst_wb_data", bus.wb_data, 32'd0);
      chk(bus.unit_sel === 3'd0, "rst_unit_sel", 32'(bus.unit_sel), 32'd0);
    end else begin
      while (busy_q.size() > 0 && busy_q[0].e < cyc) void'(busy_q.pop_front());
      exp_busy = busy_q.size() > 0 && busy_q[0].s <= cyc;
      chk(stall === exp_busy, "stall", 32'(stall), 32'(exp_busy));
      chk(bus.issue_ready === !exp_busy, "issue_ready", 32'(bus.issue_ready), 32'(!exp_busy));
      if (exp_busy) chk(bus.unit_sel === busy_q[0].op, "unit_sel", 32'(bus.unit_sel), 32'(busy_q[0].op));

      while (latch_q.size() > 0 && latch_q[0] < cyc) begin
        chk(0, "opnd_latch_missed", 32'(latch_q[0]), 32'(cyc));
        void'(latch_q.pop_front());
      end
      exp_latch = latch_q.size() > 0 && latch_q[0] == cyc;
      chk(bus.opnd_latch === exp_latch, "opnd_latch", 32'(bus.opnd_latch), 32'(exp_latch));
      if (exp_latch) void'(latch_q.pop_front());

      while (wb_q.size() > 0 && wb_q[0].cyc < cyc) begin
        chk(0, "wb_missed", 32'(wb_q[0].cyc), 32'(cyc));
        void'(wb_q.pop_front());
      end
      exp_wb = wb_q.size() > 0 && wb_q[0].cyc == cyc;
      chk(bus.wb_en === exp_wb, "wb_en", 32'(bus.wb_en), 32'(exp_wb));
      if (exp_wb) begin
        chk(bus.wb_addr === wb_q[0].addr, "wb_addr", 32'(bus.wb_addr), 32'(wb_q[0].addr));
        chk(bus.wb_data === wb_q[0].data, "wb_data", bus.wb_data, wb_q[0].data);
        last_addr = wb_q[0].addr;
        last_data = wb_q[0].data;
        void'(wb_q.pop_front());
      end else begin
        chk(bus.wb_addr === last_addr, "wb_addr_hold", 32'(bus.wb_addr), 32'(last_addr));
        chk(bus.wb_data === last_data, "wb_data_hold", bus.wb_data, last_data);
      end

      chk(fp_cond === exp_cond, "fp_cond", 32'(fp_cond), 32'(exp_cond));
      nxt_cond = exp_cond;
      while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
        chk(0, "done_missed", 32'(done_q[0].cyc), 32'(cyc));
        void'(done_q.pop_front());
      end
      exp_done = done_q.size() > 0 && done_q[0].cyc == cyc;
      chk(done === exp_done, "done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        if (done_q[0].is_ceq) nxt_cond = done_q[0].cond;
        void'(done_q.pop_front());
      end
      exp_cond = nxt_cond;
    end
  end

  initial begin
    rst_n = 0;
    bus.issue_valid = 0; bus.issue_op = 0; bus.issue_dbl = 0; bus.issue_fd = 0;
    bus.res_hi = 0; bus.res_lo = 0; bus.res_cmp = 0;
`ifdef FPU_STATUS_EN
    unit_status = 0; status_clr = 0;
`endif
    salt = $urandom;
    repeat (3) drive_cycle(0, 0, 3'd0, 0, 5'd0);
    drive_cycle(1, 0, 3'd0, 0, 5'd0);

    force_en = 1;
    force_hi = 32'h40400000; force_lo = 32'h0;
    do_op(3'd0, 0, 5'd5);
    force_hi = 32'h3FF00000; force_lo = 32'h00000001;
    do_op(3'd3, 1, 5'd30);
    force_hi = 32'hC0000000; force_lo = 32'h12345678;
    do_op(3'd0, 1, 5'd31);
    force_cmp = 1;
    do_op(3'd4, 0, 5'd7);
    force_cmp = 0;
    do_op(3'd4, 1, 5'd8);
    force_en = 0;

    // mul with issue_valid held: the model accepts a second one only once the first has finished.
    for (int i = 0; i < LAT_MUL + 6; i++) drive_cycle(1, 1, 3'd2, 0, 5'd12);
    drive_cycle(1, 0, 3'd0, 0, 5'd0);
    while (cyc + 1 < free_cyc) drive_cycle(1, 0, 3'd0, 0, 5'd0);
    do_op(3'd6, 0, 5'd9);

    do_issue(3'd3, 0, 5'd3);
    drive_cycle(1, 0, 3'd0, 0, 5'd0);
    drive_cycle(0, 0, 3'd0, 0, 5'd0);
    drive_cycle(1, 0, 3'd0, 0, 5'd0);
    do_op(3'd0, 0, 5'd14);

    for (int i = 0; i < 2500; i++)
      drive_cycle(1, $urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    repeat (40) drive_cycle(1, 0, 3'd0, 0, 5'd0);
    @(negedge clk); #1;
    chk(wb_q.size() == 0 && done_q.size() == 0 && latch_q.size() == 0,
        "drain_empty", 32'(wb_q.size() + done_q.size() + latch_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
